qsn_shift_sched_pc5: RTL and testbench
======================================

// Module: qsn_shift_sched_pc5
// PURPOSE
//  Two-requester scheduler for the length-5 QSN barrel shifter (Pc=5, q=3).
//  Round-robin shares the single QSN between requester 0 (VN-side message pass) and requester 1 (CN-side).
//  Converts each granted shift factor into registered left/right/merge select words.
//  Presents them to the QSN datapath over a valid/ready handshake.
// PARAMETERS
//  PERMUTATION_LENGTH  5   QSN length; only 5 is supported. Merge/right mapping below is fixed to it.
//  SHIFT_W             3   shift factor width
//  TAG_W               4   opaque request tag, carried to the output
//  CNT_W               16  width of the issued-beat counter
// PORTS
//  sys_clk       in   1        system clock
//  rst           in   1        synchronous reset, active-high
//  flush         in   1        sync flush of in-flight output word
//  req0_valid    in   1        requester 0 has a shift request
//  req0_ready    out  1        requester 0 request accepted this cycle
//  req0_shift    in   SHIFT_W  requester 0 shift factor
//  req0_tag      in   TAG_W    requester 0 tag
//  req1_valid    in   1        requester 1 has a shift request
//  req1_ready    out  1        requester 1 request accepted this cycle
//  req1_shift    in   SHIFT_W  requester 1 shift factor
//  req1_tag      in   TAG_W    requester 1 tag
//  qsn_valid     out  1        select words valid
//  qsn_ready     in   1        QSN consumes the select words
//  left_sel      out  3        left shifter select
//  right_sel     out  3        right shifter select
//  merge_sel     out  4        merge mux select
//  qsn_tag       out  TAG_W    tag of issued request
//  qsn_src       out  1        requester index of issued request
//  issued_cnt    out  CNT_W    saturating count of handshaked beats
//  err_shift_oor out  1        sticky: a shift factor >= 5 was accepted
// BEHAVIOUR
//  - Reset (rst=1 at edge): all outputs 0; rr pointer = 0 (req0 favoured); err flag and count cleared.
//  - Output stage is one register with a valid bit.
//    - can_accept = !qsn_valid | qsn_ready.
//    - Grant only when can_accept=1 and flush=0.
//    - reqN_ready is combinational: the grant for N. At most one of req0_ready/req1_ready is high.
//  - Arbitration: if only one valid, grant it; if both valid, grant rr pointer side.
//    - Pointer moves to the other side after every grant. No grant leaves the pointer unchanged.
//  - Latency: request accepted at edge k -> qsn_valid with selects at k+1.
//    - With qsn_ready held high, one beat per cycle, alternating sources when both requesters are valid.
//  - qsn_valid and selects/tag/src stay stable while qsn_valid=1 and qsn_ready=0.
//  - Mapping, with s the shift after reduction:
//    - s=0: left=0, right=0, merge=0000.
//    - s=1..4: left=s, right=5-s, merge=(1<<(5-s))-1, i.e. 1:1111 2:0111 3:0011 4:0001.
//  - Out-of-range shift 5,6,7: reduce mod 5 to 0,1,2, issue normally, and set err_shift_oor (sticky until rst).
//  - issued_cnt increments on each qsn_valid&qsn_ready and saturates at all-ones.
//  - flush=1: qsn_valid cleared next edge, no grant that cycle (both readies 0), pointer held.
//    - flush has priority over a same-cycle handshake. A flushed beat is not counted.
//  - rst has priority over flush and all activity. Reset mid-stall discards the held word.
// CONFIGURATION
//  QSN_SCHED_INV_SHIFT_EN defined:
//  - Adds ports req0_inv and req1_inv (in, 1 bit).
//  - When the granted request has inv=1, the issued shift is (5-s)%5, with s the reduced factor. Used for the inverse permutation on message return.
//  - Example: s=2 gives 3, so left=3, right=2, merge=0011. s=0 stays 0.
//  QSN_SCHED_INV_SHIFT_EN not defined: no inv ports; shift always issued as reduced s.
// TESTING
//  1 rst, then req0 valid only, shift=1, tag=3, qsn_ready=1 -> next cycle qsn_valid=1, left=1, right=4, merge=1111, tag=3, src=0.
//  2 both valid every cycle, shifts 2/4, qsn_ready=1 for 4 cycles -> sources 0,1,0,1; selects (2,3,0111) and (4,1,0001); issued_cnt=4.
//  3 qsn_ready=0 for 3 cycles with both valid -> both readies 0, outputs frozen. Ready high -> held word consumed, then next grant.
//  4 req1 shift=6 -> issued as 1 (left=1, right=4, merge=1111); err_shift_oor=1 and stays 1 until rst.
//  5 flush with qsn_valid=1 and qsn_ready=1 -> qsn_valid=0 next cycle, issued_cnt unchanged, no ready pulses that cycle.
//  6 [INV_SHIFT_EN] req0 shift=2 inv=1 -> left=3, right=2, merge=0011. Shift=0 inv=1 -> all selects 0.

Source files
------------

// File: rtl/qsn_shift_sched_pc5.sv
// Round-robin two-requester scheduler for the Pc=5 QSN barrel shifter: grants one shift
// request per cycle and registers its left/right/merge select words. Optional macro: QSN_SCHED_INV_SHIFT_EN.
module qsn_shift_sched_pc5 #(
    parameter int PERMUTATION_LENGTH = 5,
    parameter int SHIFT_W            = 3,
    parameter int TAG_W              = 4,
    parameter int CNT_W              = 16
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [SHIFT_W-1:0] req0_shift,
    input  logic [TAG_W-1:0]   req0_tag,
`ifdef QSN_SCHED_INV_SHIFT_EN
    input  logic               req0_inv,
    input  logic               req1_inv,
`endif
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [SHIFT_W-1:0] req1_shift,
    input  logic [TAG_W-1:0]   req1_tag,
    output logic               qsn_valid,
    input  logic               qsn_ready,
    output logic [2:0]         left_sel,
    output logic [2:0]         right_sel,
    output logic [3:0]         merge_sel,
    output logic [TAG_W-1:0]   qsn_tag,
    output logic               qsn_src,
    output logic [CNT_W-1:0]   issued_cnt,
    output logic               err_shift_oor
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high at the
    // clock edge; reqN_ready is the combinational grant and never depends on qsn_ready alone.
    logic               rr_ptr;
    logic               can_accept;
    logic               grant_en;
    logic               gnt0;
    logic               gnt1;
    logic               any_gnt;
    logic [SHIFT_W-1:0] raw_shift;
    logic [2:0]         red_shift;
    logic [2:0]         iss_shift;
    logic               oor;
    logic [2:0]         nxt_left;
    logic [2:0]         nxt_right;
    logic [3:0]         nxt_merge;

    assign can_accept = !qsn_valid || qsn_ready;
    assign grant_en   = can_accept && !flush;
    assign gnt0       = grant_en && req0_valid && (!req1_valid || !rr_ptr);
    assign gnt1       = grant_en && req1_valid && (!req0_valid || rr_ptr);
    assign any_gnt    = gnt0 || gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign raw_shift = gnt1 ? req1_shift : req0_shift;
    assign oor       = (raw_shift >= SHIFT_W'(PERMUTATION_LENGTH));
    assign red_shift = oor ? 3'(raw_shift - SHIFT_W'(PERMUTATION_LENGTH)) : 3'(raw_shift);

`ifdef QSN_SCHED_INV_SHIFT_EN
    logic sel_inv;
    assign sel_inv   = gnt1 ? req1_inv : req0_inv;
    assign iss_shift = (sel_inv && red_shift != 3'd0) ? 3'd5 - red_shift : red_shift;
`else
    assign iss_shift = red_shift;
`endif

    // Merge mask keeps the low (5-s) lanes from the right shifter.
    always_comb begin
        nxt_left  = 3'd0;
        nxt_right = 3'd0;
        nxt_merge = 4'b0000;
        case (iss_shift)
            3'd1: begin nxt_left = 3'd1; nxt_right = 3'd4; nxt_merge = 4'b1111; end
            3'd2: begin nxt_left = 3'd2; nxt_right = 3'd3; nxt_merge = 4'b0111; end
            3'd3: begin nxt_left = 3'd3; nxt_right = 3'd2; nxt_merge = 4'b0011; end
            3'd4: begin nxt_left = 3'd4; nxt_right = 3'd1; nxt_merge = 4'b0001; end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            qsn_valid     <= 1'b0;
            left_sel      <= 3'd0;
            right_sel     <= 3'd0;
            merge_sel     <= 4'd0;
            qsn_tag       <= '0;
            qsn_src       <= 1'b0;
            rr_ptr        <= 1'b0;
            issued_cnt    <= '0;
            err_shift_oor <= 1'b0;
        end else begin
            if (flush) begin
                qsn_valid <= 1'b0;
            end else if (any_gnt) begin
                qsn_valid <= 1'b1;
                left_sel  <= nxt_left;
                right_sel <= nxt_right;
                merge_sel <= nxt_merge;
                qsn_tag   <= gnt1 ? req1_tag : req0_tag;
                qsn_src   <= gnt1;
            end else if (qsn_ready) begin
                qsn_valid <= 1'b0;
            end

            if (any_gnt) begin
                rr_ptr <= gnt0;
            end

            // A beat discarded by flush never reaches the QSN, so it is not counted.
            if (qsn_valid && qsn_ready && !flush && issued_cnt != {CNT_W{1'b1}}) begin
                issued_cnt <= issued_cnt + 1'b1;
            end

            if (any_gnt && oor) begin
                err_shift_oor <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qsn_shift_sched_pc5.sv
// Directed bench for qsn_shift_sched_pc5: hand-computed select words, arbitration order,
// stall, flush, out-of-range shift and reset cases, checked with immediate assertions.
module tb_qsn_shift_sched_pc5;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_shift;
    logic [3:0]  req0_tag;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_shift;
    logic [3:0]  req1_tag;
    logic        qsn_valid;
    logic        qsn_ready;
    logic [2:0]  left_sel;
    logic [2:0]  right_sel;
    logic [3:0]  merge_sel;
    logic [3:0]  qsn_tag;
    logic        qsn_src;
    logic [15:0] issued_cnt;
    logic        err_shift_oor;
`ifdef QSN_SCHED_INV_SHIFT_EN
    logic        req0_inv;
    logic        req1_inv;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    qsn_shift_sched_pc5 dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .flush         (flush),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_shift    (req0_shift),
        .req0_tag      (req0_tag),
`ifdef QSN_SCHED_INV_SHIFT_EN
        .req0_inv      (req0_inv),
        .req1_inv      (req1_inv),
`endif
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_shift    (req1_shift),
        .req1_tag      (req1_tag),
        .qsn_valid     (qsn_valid),
        .qsn_ready     (qsn_ready),
        .left_sel      (left_sel),
        .right_sel     (right_sel),
        .merge_sel     (merge_sel),
        .qsn_tag       (qsn_tag),
        .qsn_src       (qsn_src),
        .issued_cnt    (issued_cnt),
        .err_shift_oor (err_shift_oor)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [2:0] l, input logic [2:0] r,
                            input logic [3:0] m, input logic [3:0] t, input logic s);
        chk({tag, ".valid"}, 32'(qsn_valid), 32'd1);
        chk({tag, ".left"},  32'(left_sel),  32'(l));
        chk({tag, ".right"}, 32'(right_sel), 32'(r));
        chk({tag, ".merge"}, 32'(merge_sel), 32'(m));
        chk({tag, ".tag"},   32'(qsn_tag),   32'(t));
        chk({tag, ".src"},   32'(qsn_src),   32'(s));
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".rdy0"}, 32'(req0_ready), 32'(r0));
        chk({tag, ".rdy1"}, 32'(req1_ready), 32'(r1));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; qsn_ready = 1'b0;
        req0_valid = 1'b0; req0_shift = 3'd0; req0_tag = 4'd0;
        req1_valid = 1'b0; req1_shift = 3'd0; req1_tag = 4'd0;
`ifdef QSN_SCHED_INV_SHIFT_EN
        req0_inv = 1'b0; req1_inv = 1'b0;
`endif
        tick(); tick();

        // Reset state
        chk("rst.valid", 32'(qsn_valid), 0);
        chk("rst.left",  32'(left_sel), 0);
        chk("rst.right", 32'(right_sel), 0);
        chk("rst.merge", 32'(merge_sel), 0);
        chk("rst.tag",   32'(qsn_tag), 0);
        chk("rst.src",   32'(qsn_src), 0);
        chk("rst.cnt",   32'(issued_cnt), 0);
        chk("rst.err",   32'(err_shift_oor), 0);
        rst = 1'b0;

        // Single requester, shift 1
        req0_valid = 1'b1; req0_shift = 3'd1; req0_tag = 4'd3; qsn_ready = 1'b1;
        #1 chk_rdy("t1.req", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0;
        #1 chk_word("t1.word", 3'd1, 3'd4, 4'b1111, 4'd3, 1'b0);
        tick();
        chk("t1.drain.valid", 32'(qsn_valid), 0);
        chk("t1.drain.cnt",   32'(issued_cnt), 1);

        // Fresh reset so the pointer favours req0 again
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t2.rst.cnt", 32'(issued_cnt), 0);

        // Both valid, alternating sources
        req0_valid = 1'b1; req0_shift = 3'd2; req0_tag = 4'd1;
        req1_valid = 1'b1; req1_shift = 3'd4; req1_tag = 4'd2;
        #1 chk_rdy("t2.e1", 1'b1, 1'b0);
        tick();
        chk_word("t2.w0", 3'd2, 3'd3, 4'b0111, 4'd1, 1'b0);
        chk_rdy("t2.e2", 1'b0, 1'b1);
        tick();
        chk_word("t2.w1", 3'd4, 3'd1, 4'b0001, 4'd2, 1'b1);
        chk("t2.cnt1", 32'(issued_cnt), 1);
        tick();
        chk_word("t2.w2", 3'd2, 3'd3, 4'b0111, 4'd1, 1'b0);
        tick();
        chk_word("t2.w3", 3'd4, 3'd1, 4'b0001, 4'd2, 1'b1);
        chk("t2.cnt3", 32'(issued_cnt), 3);

        // Stall: qsn_ready low, both valid
        qsn_ready = 1'b0;
        #1 chk_rdy("t3.stall0", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_word("t3.hold", 3'd4, 3'd1, 4'b0001, 4'd2, 1'b1);
            chk_rdy("t3.hold", 1'b0, 1'b0);
            chk("t3.hold.cnt", 32'(issued_cnt), 3);
        end
        qsn_ready = 1'b1;
        #1 chk_rdy("t3.release", 1'b1, 1'b0);
        tick();
        chk_word("t3.next", 3'd2, 3'd3, 4'b0111, 4'd1, 1'b0);
        chk("t3.cnt4", 32'(issued_cnt), 4);

        // Out-of-range shift 6 on req1 -> 1
        req0_valid = 1'b0;
        req1_shift = 3'd6; req1_tag = 4'd5;
        #1 chk_rdy("t4.req", 1'b0, 1'b1);
        chk("t4.err.before", 32'(err_shift_oor), 0);
        tick();
        req1_valid = 1'b0;
        #1 chk_word("t4.word", 3'd1, 3'd4, 4'b1111, 4'd5, 1'b1);
        chk("t4.err", 32'(err_shift_oor), 1);
        chk("t4.cnt5", 32'(issued_cnt), 5);
        tick();
        chk("t4.drain.valid", 32'(qsn_valid), 0);
        chk("t4.err.sticky", 32'(err_shift_oor), 1);
        chk("t4.cnt6", 32'(issued_cnt), 6);

        // Shifts 7 (->2), 5 (->0), 3 back to back from req0
        req0_valid = 1'b1; req0_shift = 3'd7; req0_tag = 4'd8;
        tick();
        req0_shift = 3'd5; req0_tag = 4'd9;
        #1 chk_word("t4b.s7", 3'd2, 3'd3, 4'b0111, 4'd8, 1'b0);
        tick();
        req0_shift = 3'd3; req0_tag = 4'd7;
        #1 chk_word("t4b.s5", 3'd0, 3'd0, 4'b0000, 4'd9, 1'b0);
        tick();
        req0_valid = 1'b0;
        #1 chk_word("t4b.s3", 3'd3, 3'd2, 4'b0011, 4'd7, 1'b0);
        chk("t4b.cnt8", 32'(issued_cnt), 8);

        // Flush with valid word and ready high; both requesters pending
        flush = 1'b1;
        req0_valid = 1'b1; req0_shift = 3'd1;
        req1_valid = 1'b1; req1_shift = 3'd2; req1_tag = 4'd6;
        #1 chk_rdy("t5.flush", 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        #1 chk("t5.valid", 32'(qsn_valid), 0);
        chk("t5.cnt", 32'(issued_cnt), 8);
        chk_rdy("t5.after", 1'b0, 1'b1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1 chk_word("t5.next", 3'd2, 3'd3, 4'b0111, 4'd6, 1'b1);
        tick();
        chk("t5.cnt9", 32'(issued_cnt), 9);

`ifdef QSN_SCHED_INV_SHIFT_EN
        // Inverse shift
        req0_valid = 1'b1; req0_shift = 3'd2; req0_inv = 1'b1; req0_tag = 4'd4;
        tick();
        req0_shift = 3'd0;
        #1 chk_word("t6.inv2", 3'd3, 3'd2, 4'b0011, 4'd4, 1'b0);
        tick();
        req0_valid = 1'b0; req0_inv = 1'b0;
        #1 chk_word("t6.inv0", 3'd0, 3'd0, 4'b0000, 4'd4, 1'b0);
        tick();
`endif

        // Reset mid-stall discards the held word and clears err/count
        qsn_ready = 1'b0;
        req1_valid = 1'b1; req1_shift = 3'd3;
        tick();
        req1_valid = 1'b0;
        #1 chk("t7.held.valid", 32'(qsn_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7.rst.valid", 32'(qsn_valid), 0);
        chk("t7.rst.err",   32'(err_shift_oor), 0);
        chk("t7.rst.cnt",   32'(issued_cnt), 0);
        chk("t7.rst.left",  32'(left_sel), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
